// File: rtl/aes128_top.sv
// Iterative AES-128 encryption engine.
// One FIPS-197 round per clock; the round key is expanded on the fly next to the
// data path. Start is an edge on AES_en seen while idle. The ciphertext is held
// in AES_data_out, and AES_data_out_valid is high for the single cycle in which
// AES_data_out is updated.
module aes128_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (addition chain); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    // Full 256-entry S-box: inverse followed by the FIPS-197 affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsm_t         fsm_reg;
    fsm_t         fsm_next;
    logic [3:0]   round_reg;
    logic [127:0] blk_reg;
    logic [127:0] rk_reg;
    logic         en_prev_reg;

    logic         start;
    logic         last_round;

    assign start      = AES_en && !en_prev_reg && (fsm_reg == IDLE);
    assign last_round = (round_reg == 4'd10);

    // ------------------------------------------------------------------
    // Data path: SubBytes -> ShiftRows -> MixColumns
    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    // ------------------------------------------------------------------
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub_shift
            assign sb[gi] = sbox(blk_reg[127-8*gi -: 8]);
            // row r = gi%4 is rotated left by r columns
            assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
            assign sr_flat[127-8*gi -: 8] = sr[gi];
            assign mc_flat[127-8*gi -: 8] = mc[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mc[4*gi+0] = xtime(sr[4*gi+0]) ^ xtime(sr[4*gi+1]) ^ sr[4*gi+1]
                              ^ sr[4*gi+2] ^ sr[4*gi+3];
            assign mc[4*gi+1] = sr[4*gi+0] ^ xtime(sr[4*gi+1]) ^ xtime(sr[4*gi+2])
                              ^ sr[4*gi+2] ^ sr[4*gi+3];
            assign mc[4*gi+2] = sr[4*gi+0] ^ sr[4*gi+1] ^ xtime(sr[4*gi+2])
                              ^ xtime(sr[4*gi+3]) ^ sr[4*gi+3];
            assign mc[4*gi+3] = xtime(sr[4*gi+0]) ^ sr[4*gi+0] ^ sr[4*gi+1]
                              ^ sr[4*gi+2] ^ xtime(sr[4*gi+3]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Key schedule: derive round key r from round key r-1 in the same cycle
    // ------------------------------------------------------------------
    logic [31:0]  key_w0, key_w1, key_w2, key_w3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;
    logic [31:0]  nk_w0, nk_w1, nk_w2, nk_w3;
    logic [7:0]   rcon;
    logic [127:0] rk_next;

    assign key_w0   = rk_reg[127:96];
    assign key_w1   = rk_reg[95:64];
    assign key_w2   = rk_reg[63:32];
    assign key_w3   = rk_reg[31:0];
    assign rot_word = {key_w3[23:0], key_w3[31:24]};

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
        end
    endgenerate

    // Round constant selected by the current round number
    always_comb begin
        rcon = 8'h00;
        case (round_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp_word = sub_word ^ {rcon, 24'h000000};
    assign nk_w0     = key_w0 ^ temp_word;
    assign nk_w1     = key_w1 ^ nk_w0;
    assign nk_w2     = key_w2 ^ nk_w1;
    assign nk_w3     = key_w3 ^ nk_w2;
    assign rk_next   = {nk_w0, nk_w1, nk_w2, nk_w3};

    logic [127:0] round_out;
    assign round_out = (last_round ? sr_flat : mc_flat) ^ rk_next;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // Next-state logic: leave IDLE on a start edge, return after round 10
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:    if (start) fsm_next = BUSY;
            BUSY:    if (last_round) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Data path registers: capture on start, one round per BUSY cycle, publish on round 10
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            en_prev_reg        <= 1'b0;
            round_reg          <= 4'd0;
            blk_reg            <= '0;
            rk_reg             <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            en_prev_reg        <= AES_en;
            AES_data_out_valid <= 1'b0;
            if (start) begin
                blk_reg   <= AES_data_in ^ AES_key_in;
                rk_reg    <= AES_key_in;
                round_reg <= 4'd1;
            end else if (fsm_reg == BUSY) begin
                blk_reg <= round_out;
                rk_reg  <= rk_next;
                if (last_round) begin
                    AES_data_out       <= round_out;
                    AES_data_out_valid <= 1'b1;
                    round_reg          <= 4'd0;
                end else begin
                    round_reg <= round_reg + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes128_top.sv
// Self-checking bench for aes128_top: known FIPS-197 vectors, control corner
// cases and random vectors against a byte-level AES-128 reference model.
module tb_aes128_top;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         dval;

    aes128_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (dval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pulse_cnt   = 0;
    int last_pulse  = -1;
    int start_cyc   = 0;

    logic [7:0] sbox_tab [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Every wait goes through here: advance to the next falling edge and log valid pulses
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dval === 1'b1) begin
            pulse_cnt++;
            last_pulse = cyc;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box generated by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_tab[st[j]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    st[row+4*col] = t[row+4*((col+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) st[j] = st[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic start(input logic [127:0] pt, input logic [127:0] key);
        din = pt;
        kin = key;
        en  = 1'b1;
        step();
        start_cyc = cyc;
    endtask

    task automatic wait_valid(input string tag, input logic [127:0] exp);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (n = 1; n <= 30; n++) begin
            step();
            if (dval === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {127'd0, seen}, 128'd1);
        if (seen) begin
            chk({tag, "_latency"}, 128'(cyc - start_cyc), 128'd10);
            chk({tag, "_data"}, dout, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, key, exp;
        int p0, v1;

        build_sbox();
        rst_n = 1'b0;
        en    = 1'b0;
        din   = '0;
        kin   = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_dout", dout, 128'd0);
            chk("rst_valid", {127'd0, dval}, 128'd0);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_dout", dout, 128'd0);
        chk("post_rst_valid", {127'd0, dval}, 128'd0);

        // FIPS-197 C.1, single-cycle valid
        start(C1_PT, C1_KEY);
        en = 1'b0;
        wait_valid("c1", C1_CT);
        step();
        chk("c1_valid_width", {127'd0, dval}, 128'd0);
        chk("c1_model", dout, aes_ref(C1_PT, C1_KEY));

        // Appendix B with AES_en held high for 51 cycles
        p0 = pulse_cnt;
        v1 = cyc;
        start(B_PT, B_KEY);
        wait_valid("appb", B_CT);
        while (cyc - v1 < 51) step();
        chk("appb_pulses", 128'(pulse_cnt - p0), 128'd1);
        chk("appb_hold", dout, B_CT);
        en = 1'b0;
        step();

        // Input changes after capture have no effect
        pt  = rand128();
        key = rand128();
        exp = aes_ref(pt, key);
        start(pt, key);
        repeat (3) step();
        din = rand128();
        kin = rand128();
        wait_valid("chg", exp);
        en  = 1'b0;
        din = rand128();
        kin = rand128();
        p0  = pulse_cnt;
        repeat (15) step();
        chk("chg_hold", dout, exp);
        chk("chg_pulses", 128'(pulse_cnt - p0), 128'd0);

        // All-zero vector, then immediate restart with Appendix B
        start('0, '0);
        en = 1'b0;
        wait_valid("zero", Z_CT);
        v1 = last_pulse;
        start(B_PT, B_KEY);
        en = 1'b0;
        wait_valid("toggle_b", B_CT);
        chk("pulse_gap", 128'(last_pulse - v1), 128'd11);

        // A rising edge while busy is ignored and not queued
        pt  = rand128();
        key = rand128();
        exp = aes_ref(pt, key);
        start(pt, key);
        en = 1'b0;
        repeat (2) step();
        din = rand128();
        kin = rand128();
        en  = 1'b1;
        step();
        en  = 1'b0;
        wait_valid("busy_edge", exp);
        p0 = pulse_cnt;
        repeat (15) step();
        chk("busy_edge_pulses", 128'(pulse_cnt - p0), 128'd0);
        chk("busy_edge_hold", dout, exp);

        // Reset during round 5 aborts with no valid pulse
        start(C1_PT, C1_KEY);
        en = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("abort_dout", dout, 128'd0);
        chk("abort_valid", {127'd0, dval}, 128'd0);
        step();
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (15) step();
        chk("abort_pulses", 128'(pulse_cnt - p0), 128'd0);
        chk("abort_dout_after", dout, 128'd0);
        start(C1_PT, C1_KEY);
        en = 1'b0;
        wait_valid("abort_restart", C1_CT);

        // AES_en already high when reset releases counts as a start
        rst_n = 1'b0;
        step();
        din   = B_PT;
        kin   = B_KEY;
        en    = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        start_cyc = cyc;
        en = 1'b0;
        wait_valid("rst_en_high", B_CT);

        // Random vectors against the reference model
        for (int i = 0; i < 8; i++) begin
            pt  = rand128();
            key = rand128();
            exp = aes_ref(pt, key);
            start(pt, key);
            en = 1'b0;
            wait_valid($sformatf("rand%0d", i), exp);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
